golden_nonce_collector: RTL

//  Lossless golden-nonce aggregator between NUM_CORES hashcores and jtag_comm.

---
 rtl/gn_pkg.sv | 17 +
 rtl/gn_fifo.sv | 66 ++++++
 rtl/golden_nonce_collector.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/gn_pkg.sv
// Shared constants and helpers for the golden-nonce collection path.
package gn_pkg;

  localparam int NONCE_W = 32;
  localparam int DROP_W  = 16;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/gn_fifo.sv
// First-word-fall-through circular FIFO with synchronous flush and occupancy count.
// A push is accepted when not full, or when full but popping in the same cycle.
// A pop is ignored while empty. Flush beats push and pop.
module gn_fifo
  import gn_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW   = clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             hash_clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);

  // Head is shown directly from storage; forced to zero while empty.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; nothing reads it until a push makes it valid.
  always_ff @(posedge hash_clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; DEPTH is a power of two so the pointers wrap naturally.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/golden_nonce_collector.sv
// Lossless golden-nonce aggregator: per-core pending slots, round-robin
// arbiter and a result FIFO presented as a valid/ready stream.
// Optional feature macro: GN_CORE_TAG_EN adds out_core, the index of the
// core that produced out_nonce, carried alongside each nonce in the FIFO.
module golden_nonce_collector
  import gn_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int FIFO_DEPTH = 8,
  localparam int CORE_W    = (NUM_CORES > 1) ? clog2(NUM_CORES) : 1,
  localparam int CNT_W     = clog2(FIFO_DEPTH) + 1
) (
  input  logic                         hash_clk,
  input  logic                         reset,
  input  logic                         new_work,
  input  logic [NUM_CORES-1:0]         gn_match_i,
  input  logic [NUM_CORES*NONCE_W-1:0] golden_nonce_i,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NONCE_W-1:0]           out_nonce,
  output logic [CNT_W-1:0]             fifo_count,
`ifdef GN_CORE_TAG_EN
  output logic [CORE_W-1:0]            out_core,
`endif
  output logic [DROP_W-1:0]            drop_count
);

`ifdef GN_CORE_TAG_EN
  localparam int ENTRY_W = NONCE_W + CORE_W;
`else
  localparam int ENTRY_W = NONCE_W;
`endif

  // Pending slots, one per core.
  logic [NUM_CORES-1:0] pend_valid;
  logic [NONCE_W-1:0]   pend_nonce [NUM_CORES];
  logic [CORE_W-1:0]    rr_ptr;

  // Arbitration results.
  logic                 can_grant;
  logic                 grant_valid;
  logic [CORE_W-1:0]    grant_idx;
  logic [NUM_CORES-1:0] grant_onehot;
  logic [NONCE_W-1:0]   grant_nonce;

  // Capture / drop bookkeeping.
  logic [NUM_CORES-1:0] capture_mask;
  logic [NUM_CORES-1:0] drop_mask;
  logic [DROP_W:0]      drop_sum;
  logic [DROP_W-1:0]    drop_next;

  // FIFO interface.
  logic               fifo_pop;
  logic               fifo_empty;
  logic               fifo_full;
  logic [ENTRY_W-1:0] fifo_wr_data;
  logic [ENTRY_W-1:0] fifo_rd_data;

  assign out_valid = !fifo_empty;
  // A pop in a new_work cycle is void: the flush empties the FIFO anyway.
  assign fifo_pop  = out_valid && out_ready && !new_work;
  assign can_grant = !new_work && (!fifo_full || fifo_pop);

  // Round-robin pick: lowest pending index at or above rr_ptr, else lowest below it.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_valid  = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    grant_nonce  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!grant_valid && pend_valid[i] && (i >= int'(rr_ptr))) begin
        grant_valid     = 1'b1;
        grant_idx       = CORE_W'(i);
        grant_onehot[i] = 1'b1;
        grant_nonce     = pend_nonce[i];
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!grant_valid && pend_valid[i] && (i < int'(rr_ptr))) begin
        grant_valid     = 1'b1;
        grant_idx       = CORE_W'(i);
        grant_onehot[i] = 1'b1;
        grant_nonce     = pend_nonce[i];
      end
    end
    if (!can_grant) begin
      grant_valid  = 1'b0;
      grant_onehot = '0;
    end
  end

  // Per-core capture decision: a busy slot that is not being drained loses the new match.
  always_comb begin
    capture_mask = '0;
    drop_mask    = '0;
    if (!new_work) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (gn_match_i[i]) begin
          if (pend_valid[i] && !grant_onehot[i]) drop_mask[i]    = 1'b1;
          else                                   capture_mask[i] = 1'b1;
        end
      end
    end
  end

  // Saturating accumulation of this cycle's drops.
  always_comb begin
    drop_sum = {1'b0, drop_count};
    for (int i = 0; i < NUM_CORES; i++) begin
      drop_sum = drop_sum + {{DROP_W{1'b0}}, drop_mask[i]};
    end
    drop_next = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  // Slot valid flags: flushed by new_work, cleared on grant, set on capture.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset)         pend_valid <= '0;
    else if (new_work) pend_valid <= '0;
    else               pend_valid <= (pend_valid & ~grant_onehot) | capture_mask;
  end

  // Slot nonce storage, only meaningful while the matching valid flag is set.
  always_ff @(posedge hash_clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (capture_mask[i]) pend_nonce[i] <= golden_nonce_i[i*NONCE_W +: NONCE_W];
    end
  end

  // Round-robin pointer moves just past the winner; holds when nothing is granted.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == CORE_W'(NUM_CORES - 1)) ? '0 : grant_idx + CORE_W'(1);
    end
  end

  // Lost-result counter; survives new_work, cleared only by reset.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) drop_count <= '0;
    else       drop_count <= drop_next;
  end

`ifdef GN_CORE_TAG_EN
  assign fifo_wr_data = {grant_idx, grant_nonce};
  assign out_core     = fifo_rd_data[NONCE_W +: CORE_W];
`else
  assign fifo_wr_data = grant_nonce;
`endif
  assign out_nonce = fifo_rd_data[NONCE_W-1:0];

  gn_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .hash_clk (hash_clk),
    .reset    (reset),
    .flush    (new_work),
    .push     (grant_valid),
    .pop      (fifo_pop),
    .wr_data  (fifo_wr_data),
    .rd_data  (fifo_rd_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

endmodule
